// File: rtl/ofmap_write_packer.sv
// ofmap_write_packer: packs LANES input beats into one memory word and writes num_words words from base_addr
// clock, reset             rising-edge clock, asynchronous active-high reset
// start, base_addr, num_w  job launch and parameters, sampled only in IDLE
// in_valid, in_data, in_ready  input beat stream, accepted when in_valid & in_ready
// we, wraddress, wdata     memory write port, we pulses one cycle per packed word
// busy, done               busy while not IDLE, done pulses for the single DONE cycle
module ofmap_write_packer #(
  parameter int LANES = 4,
  parameter int LANE_WIDTH = 128,
  parameter int ADDR_BITS = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_BITS-1:0]          base_addr,
  input  logic [ADDR_BITS:0]            num_words,
  input  logic                          in_valid,
  input  logic [LANE_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          we,
  output logic [ADDR_BITS-1:0]          wraddress,
  output logic [LANES*LANE_WIDTH-1:0]   wdata,
  output logic                          busy,
  output logic                          done
);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [ADDR_BITS:0] W1 = 1;
  typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;
  state_t state, state_n;
  logic [LW-1:0] lane_cnt;
  logic [ADDR_BITS:0] word_cnt, num_q;
  logic [ADDR_BITS-1:0] addr_cnt;
  logic [(LANES-1)*LANE_WIDTH-1:0] buffer;
  logic acc, word_end;
  assign in_ready = state == PACK;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign acc = in_valid & in_ready;
  assign word_end = acc & (lane_cnt == LAST_LANE);
  always_comb
    state_n = state == IDLE ? (start ? (num_words == '0 ? DONE : PACK) : IDLE) :
              state == PACK ? (word_end && word_cnt == num_q - W1 ? DONE : PACK) : IDLE;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      lane_cnt <= '0;
      word_cnt <= '0;
      num_q <= '0;
      addr_cnt <= '0;
      buffer <= '0;
      we <= 1'b0;
      wraddress <= '0;
      wdata <= '0;
    end else begin
      we <= 1'b0;
      if (state == IDLE && start) begin
        addr_cnt <= base_addr;
        num_q <= num_words;
        word_cnt <= '0;
        lane_cnt <= '0;
      end
      if (acc) begin
        lane_cnt <= word_end ? '0 : lane_cnt + LW'(1);
        for (int k = 0; k < LANES - 1; k++)
          if (lane_cnt == LW'(k)) buffer[k*LANE_WIDTH +: LANE_WIDTH] <= in_data;
        if (word_end) begin
          wdata <= {in_data, buffer};
          wraddress <= addr_cnt;
          we <= 1'b1;
          addr_cnt <= addr_cnt + ADDR_BITS'(1);
          word_cnt <= word_cnt + W1;
        end
      end
    end
endmodule

// File: tb/tb_ofmap_write_packer.sv
// tb_ofmap_write_packer: randomized jobs checked every cycle against a beat-counting reference model
module tb_ofmap_write_packer;
  localparam int L = 4, LWD = 128, AB = 10, WW = L * LWD;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [AB-1:0] base_addr = '0;
  logic [AB:0] num_words = '0;
  logic [LWD-1:0] in_data = '0;
  logic in_ready, we, busy, done;
  logic [AB-1:0] wraddress;
  logic [WW-1:0] wdata;
  int vectors = 0, errors = 0, cyc = 0;
  int st_cyc, done_cyc, wecnt;
  int we_cyc[$];
  logic [WW-1:0] mem [1024];
  bit wrote [1024];
  int m_phase, m_beats, m_num;
  logic [AB-1:0] m_base;
  logic [LWD-1:0] cur[$];
  logic e_ready, e_we, e_busy, e_done;
  logic [AB-1:0] e_addr;
  logic [WW-1:0] e_data;

  ofmap_write_packer #(.LANES(L), .LANE_WIDTH(LWD), .ADDR_BITS(AB)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .we(we), .wraddress(wraddress),
    .wdata(wdata), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [LWD-1:0] beat(input int tag, input int k);
    return {4{32'(tag * 256 + k)}};
  endfunction

  function automatic logic [WW-1:0] word(input int tag, input int w);
    return {beat(tag, 4*w+3), beat(tag, 4*w+2), beat(tag, 4*w+1), beat(tag, 4*w)};
  endfunction

  // Compare outputs mid-cycle, then advance the model with the inputs the next edge will sample.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      m_phase = 0;
      cur.delete();
      e_ready = 0; e_we = 0; e_busy = 0; e_done = 0; e_addr = '0; e_data = '0;
    end
    chk("in_ready", in_ready, e_ready);
    chk("we", we, e_we);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("wraddress", wraddress, e_addr);
    chk("wdata", wdata, e_data);
    if (we) begin
      mem[wraddress] = wdata;
      wrote[wraddress] = 1'b1;
      wecnt++;
      we_cyc.push_back(cyc);
    end
    if (done) done_cyc = cyc;
    if (!reset) begin
      e_we = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_base = base_addr;
          m_num = int'(num_words);
          m_beats = 0;
          m_phase = m_num == 0 ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        if (in_valid) begin
          cur.push_back(in_data);
          m_beats++;
          if (cur.size() == L) begin
            e_we = 1;
            e_addr = AB'((int'(m_base) + m_beats / L - 1) % (1 << AB));
            for (int k = 0; k < L; k++) e_data[k*LWD +: LWD] = cur[k];
            cur.delete();
            if (m_beats == L * m_num) m_phase = 2;
          end
        end
      end else m_phase = 0;
      e_ready = m_phase == 1;
      e_busy = m_phase != 0;
      e_done = m_phase == 2;
    end
  end

  task automatic run_job(input int base, input int num, input int gap, input int tag, input int poke);
    int i, t;
    i = 0;
    t = 0;
    @(posedge clock);
    #1;
    start = 1'b1;
    base_addr = AB'(base);
    num_words = (AB+1)'(num);
    st_cyc = cyc + 1;
    wecnt = 0;
    done_cyc = -1;
    we_cyc.delete();
    @(posedge clock);
    #1;
    start = 1'b0;
    while (i < L * num && t < 20000) begin
      in_valid = $urandom_range(99) >= gap;
      in_data = tag != 0 ? beat(tag, i) : {$urandom, $urandom, $urandom, $urandom};
      start = i == poke;
      if (start) begin
        base_addr = 10'h200;
        num_words = 11'd5;
      end
      if (in_valid && in_ready) i++;
      @(posedge clock);
      #1;
      t++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (t >= 20000) chk("beat_timeout", 1'b1, 1'b0);
    t = 0;
    while (busy && t < 20) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("idle_after_job", busy, 1'b0);
  endtask

  initial begin
    @(posedge clock);
    #1;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_wdata", wdata, '0);
    chk("rst_wraddress", wraddress, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    run_job(16'h010, 2, 0, 1, -1);
    chk("t1_we_count", wecnt, 2);
    chk("t1_we0_cycle", we_cyc[0] - st_cyc, 4);
    chk("t1_we1_cycle", we_cyc[1] - st_cyc, 8);
    chk("t1_done_with_we", done_cyc, we_cyc[1]);
    chk("t1_word0", mem[10'h010], word(1, 0));
    chk("t1_word1", mem[10'h011], word(1, 1));

    for (int w = 0; w < 3; w++) mem[10'h050 + w] = '0;
    run_job(16'h050, 3, 50, 2, -1);
    chk("t2_we_count", wecnt, 3);
    for (int w = 0; w < 3; w++) chk("t2_word", mem[10'h050 + w], word(2, w));

    run_job(16'h3FF, 2, 30, 3, -1);
    chk("t3_we_count", wecnt, 2);
    chk("t3_word_3ff", mem[10'h3FF], word(3, 0));
    chk("t3_word_000", mem[10'h000], word(3, 1));

    run_job(16'h123, 0, 0, 4, -1);
    chk("t4_we_count", wecnt, 0);
    chk("t4_done_cycle", done_cyc, st_cyc);

    wecnt = 0;
    @(posedge clock);
    #1;
    start = 1'b1;
    base_addr = 10'h100;
    num_words = 11'd2;
    @(posedge clock);
    #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = beat(5, 0);
    @(posedge clock);
    #1;
    in_data = beat(5, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t5_busy_in_reset", busy, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("t5_we_count", wecnt, 0);
    run_job(16'h020, 1, 0, 6, -1);
    chk("t5_we_count_after", wecnt, 1);
    chk("t5_word", mem[10'h020], word(6, 0));

    wrote[10'h200] = 1'b0;
    run_job(16'h040, 2, 0, 7, 3);
    chk("t6_we_count", wecnt, 2);
    chk("t6_word1", mem[10'h041], word(7, 1));
    chk("t6_no_stray", wrote[10'h200], 1'b0);

    repeat (8) begin
      int n;
      n = $urandom_range(1, 6);
      run_job($urandom_range(0, 1023), n, $urandom_range(0, 70), 0, $urandom_range(0, 30));
      chk("rand_we_count", wecnt, n);
    end

    run_job(16'h123, 1024, 0, 0, -1);
    chk("full_we_count", wecnt, 1024);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
